// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with a
// valid/ready handshake, synchronous flush to a bubble, and an optional
// two-entry skid buffer that registers the upstream ready path.
//
// Ports:
//   clk        rising-edge clock
//   clear      asynchronous active-low reset
//   flush      synchronous squash, empties the stage
//   in_valid   upstream payload present
//   in_ready   stage accepts this cycle (registered when SKID=1)
//   in_data    upstream payload
//   out_valid  out_data valid (main register valid bit)
//   out_ready  downstream consumes this cycle
//   out_data   payload to next stage, straight from the main register
//   occupancy  number of entries held
module pipe_stage_reg #(
    parameter int unsigned        DATA_W = 96,
    parameter logic [DATA_W-1:0]  BUBBLE = {DATA_W{1'b0}},
    parameter bit                 SKID   = 1'b1
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              main_v_q,    main_v_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              skid_v_q,    skid_v_d;
    logic              rdy_q,       rdy_d;
    logic [1:0]        occ_q,       occ_d;

    logic accept_c;
    logic drain_c;

    // Skid mode: ready comes straight from a flop, so out_ready never reaches
    // in_ready combinationally. Single-entry mode: ready looks through a drain.
    assign in_ready  = SKID ? rdy_q : (!main_v_q || out_ready);
    assign accept_c  = in_valid && in_ready;
    assign drain_c   = main_v_q && out_ready;

    assign out_valid = main_v_q;
    assign out_data  = main_data_q;
    assign occupancy = occ_q;

    // Next-state: flush wins; then skid refill, main load/empty, skid capture.
    always_comb begin
        main_data_d = main_data_q;
        main_v_d    = main_v_q;
        skid_data_d = skid_data_q;
        skid_v_d    = skid_v_q;

        if (flush) begin
            main_data_d = BUBBLE;
            main_v_d    = 1'b0;
            skid_data_d = BUBBLE;
            skid_v_d    = 1'b0;
        end else if (SKID) begin
            if (skid_v_q && drain_c) begin
                // in_ready is low whenever skid is full, so no accept here
                main_data_d = skid_data_q;
                main_v_d    = 1'b1;
                skid_v_d    = 1'b0;
            end else if (!main_v_q || drain_c) begin
                if (accept_c) begin
                    main_data_d = in_data;
                    main_v_d    = 1'b1;
                end else begin
                    main_v_d    = 1'b0;
                end
            end else if (accept_c) begin
                // main stalled: absorb the in-flight payload into skid
                skid_data_d = in_data;
                skid_v_d    = 1'b1;
            end
        end else begin
            if (accept_c) begin
                main_data_d = in_data;
                main_v_d    = 1'b1;
            end else if (drain_c) begin
                main_v_d    = 1'b0;
            end
        end

        rdy_d = !skid_v_d;
        occ_d = 2'(main_v_d) + 2'(skid_v_d);
    end

    // State registers
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            main_data_q <= BUBBLE;
            main_v_q    <= 1'b0;
            skid_data_q <= BUBBLE;
            skid_v_q    <= 1'b0;
            rdy_q       <= 1'b1;
            occ_q       <= 2'd0;
        end else begin
            main_data_q <= main_data_d;
            main_v_q    <= main_v_d;
            skid_data_q <= skid_data_d;
            skid_v_q    <= skid_v_d;
            rdy_q       <= rdy_d;
            occ_q       <= occ_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: drives a SKID=1 and a SKID=0 instance with
// shared stimulus; a mode flag selects which instance the scoreboard follows.
module tb_pipe_stage_reg;

    localparam int unsigned DATA_W = 96;

    logic              clk;
    logic              clear;
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              out_ready;

    logic              ir1, ov1, ir0, ov0;
    logic [DATA_W-1:0] od1, od0;
    logic [1:0]        occ1, occ0;

    logic              mode;   // 1: follow SKID=1 instance, 0: SKID=0 instance
    logic              ir, ov;
    logic [DATA_W-1:0] od;
    logic [1:0]        occ;

    assign ir  = mode ? ir1  : ir0;
    assign ov  = mode ? ov1  : ov0;
    assign od  = mode ? od1  : od0;
    assign occ = mode ? occ1 : occ0;

    pipe_stage_reg #(.DATA_W(DATA_W), .SKID(1'b1)) dut1 (
        .clk(clk), .clear(clear), .flush(flush),
        .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .SKID(1'b0)) dut0 (
        .clk(clk), .clear(clear), .flush(flush),
        .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
        .occupancy(occ0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int                n_checks = 0;
    int                n_errors = 0;
    logic [DATA_W-1:0] q[$];
    logic              acc;
    logic              stall_prev;
    logic [DATA_W-1:0] prev_data;
    int                n_out;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: evaluate model at negedge, commit at posedge, return #1 after.
    task automatic cycle();
        logic             e_ir;
        logic [DATA_W-1:0] e;
        @(negedge clk);
        acc = 1'b0;
        if (!clear) begin
            q.delete();
            stall_prev = 1'b0;
        end else begin
            chk("occupancy", 128'(occ), 128'(q.size()));
            chk("out_valid", 128'(ov), 128'(q.size() != 0));
            e_ir = mode ? (q.size() < 2) : (q.size() == 0 || out_ready);
            chk("in_ready", 128'(ir), 128'(e_ir));
            if (stall_prev) chk("stable_data", 128'(od), 128'(prev_data));
            acc = in_valid && ir;
            if (ov && out_ready && q.size() > 0) begin
                e = q.pop_front();
                chk("out_data", 128'(od), 128'(e));
                n_out++;
            end
            if (flush) q.delete();
            else if (acc) q.push_back(in_data);
            stall_prev = ov && !out_ready && !flush;
            prev_data  = od;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        cycle(); cycle();
        clear = 1'b1;
    endtask

    task automatic run_random(input int n);
        in_valid = 1'b0; flush = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (acc || !in_valid) begin
                in_valid = ($urandom_range(99) < 70);
                in_data  = {$urandom, $urandom, $urandom};
            end
            out_ready = ($urandom_range(99) < 60);
            flush     = ($urandom_range(99) == 0);
            cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) cycle();
        chk("random_drained", 128'(q.size()), 128'(0));
    endtask

    initial begin
        logic [DATA_W-1:0] a5;
        a5 = {12{8'hA5}};
        mode = 1'b1; acc = 1'b0; stall_prev = 1'b0; prev_data = '0; n_out = 0;
        clear = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #2;

        // Reset held for 3 cycles with a payload offered
        clear = 1'b0; in_valid = 1'b1; in_data = a5;
        repeat (3) cycle();
        chk("rst_out_valid1", 128'(ov1), 128'(0));
        chk("rst_out_data1", 128'(od1), 128'(0));
        chk("rst_occ1", 128'(occ1), 128'(0));
        chk("rst_in_ready1", 128'(ir1), 128'(1));
        chk("rst_out_valid0", 128'(ov0), 128'(0));
        chk("rst_in_ready0", 128'(ir0), 128'(1));
        clear = 1'b1;
        cycle();
        chk("first_accept_valid", 128'(ov1), 128'(1));
        chk("first_accept_data", 128'(od1), 128'(a5));

        // Asynchronous reset mid-transfer
        in_data = 96'd55; cycle();
        #2 clear = 1'b0;
        #1;
        chk("async_rst_valid", 128'(ov1), 128'(0));
        chk("async_rst_occ", 128'(occ1), 128'(0));
        chk("async_rst_data", 128'(od1), 128'(0));
        chk("async_rst_ready", 128'(ir1), 128'(1));
        @(posedge clk); #1;
        do_reset();

        // Streaming 1..100 with out_ready high
        out_ready = 1'b1; in_valid = 1'b1; n_out = 0;
        for (int i = 1; i <= 100; i++) begin
            in_data = 96'(i);
            cycle();
            chk("stream_accept", 128'(acc), 128'(1));
        end
        in_valid = 1'b0; cycle(); cycle();
        chk("stream_count", 128'(n_out), 128'(100));

        // SKID=1 stall absorbs one extra payload
        n_out = 0;
        in_valid = 1'b1; in_data = 96'd1; out_ready = 1'b1; cycle();
        in_data = 96'd2; out_ready = 1'b0; cycle();
        chk("stall_occ", 128'(occ1), 128'(2));
        chk("stall_in_ready", 128'(ir1), 128'(0));
        chk("stall_data", 128'(od1), 128'(1));
        in_data = 96'd3; cycle();
        chk("stall_hold", 128'(od1), 128'(1));
        out_ready = 1'b1; cycle();
        cycle();
        in_data = 96'd4; cycle();
        in_valid = 1'b0; cycle(); cycle();
        chk("stall_count", 128'(n_out), 128'(4));

        // Flush with two entries held and a concurrent offer
        in_valid = 1'b1; in_data = 96'd7; out_ready = 1'b1; cycle();
        in_data = 96'd8; out_ready = 1'b0; cycle();
        chk("pre_flush_occ", 128'(occ1), 128'(2));
        flush = 1'b1; in_data = 96'd9; cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 128'(ov1), 128'(0));
        chk("flush_occ", 128'(occ1), 128'(0));
        chk("flush_data", 128'(od1), 128'(0));
        chk("flush_ready", 128'(ir1), 128'(1));
        out_ready = 1'b1; cycle(); cycle();

        run_random(10000);

        // SKID=0 combinational back-pressure
        mode = 1'b0;
        do_reset();
        in_valid = 1'b1; in_data = 96'd5; out_ready = 1'b1; cycle();
        in_data = 96'd6; out_ready = 1'b0; #1;
        chk("s0_ready_low", 128'(ir0), 128'(0));
        out_ready = 1'b1; #1;
        chk("s0_ready_high", 128'(ir0), 128'(1));
        cycle();
        chk("s0_replace", 128'(od0), 128'(6));
        chk("s0_occ", 128'(occ0), 128'(1));
        in_valid = 1'b0; cycle();

        run_random(5000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
